// File: rtl/dist_uart_reporter_pkg.sv
// dist_report_pkg: shared ASCII codes, line FSM encoding and BCD sizing for the distance reporter
package dist_report_pkg;
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] SPACE    = 8'h20;
  localparam logic [7:0] COLON    = 8'h3A;
  localparam logic [7:0] ZERO     = 8'h30;
  localparam logic [7:0] NINE     = 8'h39;
  localparam logic [7:0] LETTER_A = 8'h41;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CONV, S_PFX, S_SEP, S_DIG, S_CR, S_LF} state_t;
  function automatic int bcd_width(input int digits);
    return 4 * (digits + 1);
  endfunction
endpackage

// File: rtl/dist_uart_reporter_if.sv
// dist_uart_reporter_if: valid/ready byte stream from the reporter to the UART transmitter
interface dist_uart_reporter_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  modport master(output tx_byte, output tx_valid, input tx_ready);
  modport slave(input tx_byte, input tx_valid, output tx_ready);
endinterface

// File: rtl/dist_uart_reporter_bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary to BCD converter with overflow flag
module bin2bcd_seq
  import dist_report_pkg::*;
#(
  parameter int W      = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);
  localparam int BW = bcd_width(DIGITS);
  localparam int CW = $clog2(W + 1);
  logic [BW-1:0] acc, adj;
  logic [W-1:0]  sh;
  logic [CW-1:0] cnt;
  logic          sticky;
  // add 3 to every BCD nibble that is 5 or more before the next shift
  always_comb begin
    adj = acc;
    for (int n = 0; n < BW / 4; n++)
      adj[4*n +: 4] = (acc[4*n +: 4] >= 4'd5) ? acc[4*n +: 4] + 4'd3 : acc[4*n +: 4];
  end
  // one shift per cycle; bits pushed out of the top nibble are remembered as overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      sh     <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc    <= '0;
        sh     <= bin;
        cnt    <= CW'(W);
        sticky <= 1'b0;
      end else if (cnt != '0) begin
        acc    <= {adj[BW-2:0], sh[W-1]};
        sh     <= sh << 1;
        sticky <= sticky | adj[BW-1];
        cnt    <= cnt - CW'(1);
        done   <= cnt == CW'(1);
      end
    end
  end
  assign bcd = acc[4*DIGITS-1:0];
  assign ovf = sticky | (acc[BW-1 -: 4] != 4'd0);
endmodule

// File: rtl/dist_uart_reporter.sv
// dist_uart_reporter: latches multi-channel distances, prints each as an ASCII line and drives proximity alarms
module dist_uart_reporter
  import dist_report_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int W          = 16,
  parameter int DIGITS     = 5,
  parameter int PREFIX_EN  = 1,
  parameter int ZERO_BLANK = 0,
  parameter int HYST       = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       sample_valid,
  input  logic [NCH*W-1:0]     sample_data,
  input  logic [W-1:0]         threshold,
  dist_uart_reporter_if.master tx,
  output logic [NCH-1:0]       alarm,
  output logic                 busy,
  output logic                 overrun
);
  logic [W-1:0]          hold [NCH];
  logic [NCH-1:0]        pend, load_hit;
  state_t                state, nxt;
  logic [2:0]            ptr, pick, cur, dcnt;
  logic                  lead, done, ovf, xfer, last;
  logic [4*DIGITS-1:0]   bcd;
  logic [3:0]            d;
  logic [7:0]            dig_char;
  int                    c;
  bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) u_conv (
    .clk  (clk),
    .rst_n(rst_n),
    .start(state == S_LOAD),
    .bin  (hold[pick]),
    .done (done),
    .bcd  (bcd),
    .ovf  (ovf)
  );
  // round-robin pick: first pending channel at or after the pointer, wrapping
  always_comb begin
    pick = ptr;
    c = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= NCH) c -= NCH;
      if (pend[c]) pick = 3'(c);
    end
    load_hit = (state == S_LOAD) ? (NCH'(1) << pick) : '0;
  end
  // sample capture; a reload of a still-pending channel not being loaded is an overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < NCH; i++) hold[i] <= '0;
    end else begin
      overrun <= |(sample_valid & pend & ~load_hit);
      for (int i = 0; i < NCH; i++) begin
        if (sample_valid[i]) begin
          hold[i] <= sample_data[i*W +: W];
          pend[i] <= 1'b1;
        end else if (load_hit[i]) pend[i] <= 1'b0;
      end
    end
  end
  // proximity alarm: set below threshold, release only at threshold+HYST or above
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alarm <= '0;
    else
      for (int i = 0; i < NCH; i++)
        if (sample_valid[i])
          alarm[i] <= (sample_data[i*W +: W] < threshold) ? 1'b1 :
                      ({1'b0, sample_data[i*W +: W]} >= {1'b0, threshold} + (W+1)'(HYST)) ? 1'b0 : alarm[i];
  end
  // line FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  end
  // line FSM transitions; byte states advance only on an accepted transfer
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = (pend != '0) ? S_LOAD : S_IDLE;
      S_LOAD:  nxt = S_CONV;
      S_CONV:  nxt = done ? ((PREFIX_EN != 0) ? S_PFX : S_DIG) : S_CONV;
      S_PFX:   nxt = xfer ? S_SEP : S_PFX;
      S_SEP:   nxt = xfer ? S_DIG : S_SEP;
      S_DIG:   nxt = (xfer && last) ? S_CR : S_DIG;
      S_CR:    nxt = xfer ? S_LF : S_CR;
      S_LF:    nxt = xfer ? S_IDLE : S_LF;
      default: nxt = S_IDLE;
    endcase
  end
  // pointer, current channel, digit counter and leading-zero tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= '0;
      cur  <= '0;
      dcnt <= '0;
      lead <= 1'b1;
    end else if (state == S_LOAD) begin
      ptr  <= (pick == 3'(NCH - 1)) ? 3'd0 : pick + 3'd1;
      cur  <= pick;
      dcnt <= '0;
      lead <= 1'b1;
    end else if (state == S_DIG && xfer) begin
      dcnt <= dcnt + 3'd1;
      lead <= lead && (d == 4'd0);
    end
  end
  // byte stream outputs derived from state only, so they hold steady through stalls
  always_comb begin
    d        = bcd[4*(DIGITS-1-int'(dcnt)) +: 4];
    last     = dcnt == 3'(DIGITS - 1);
    dig_char = ovf ? NINE :
               (ZERO_BLANK != 0 && lead && d == 4'd0 && !last) ? SPACE : ZERO + {4'd0, d};
    tx.tx_valid = state inside {S_PFX, S_SEP, S_DIG, S_CR, S_LF};
    tx.tx_byte  = (state == S_PFX) ? LETTER_A + {5'd0, cur} :
                  (state == S_SEP) ? COLON :
                  (state == S_DIG) ? dig_char :
                  (state == S_CR)  ? CR :
                  (state == S_LF)  ? LF : 8'h00;
    busy = state != S_IDLE;
    xfer = tx.tx_valid && tx.tx_ready;
  end
endmodule

// File: tb/tb_dist_uart_reporter.sv
// tb_dist_uart_reporter: directed checks of line format, stalls, blanking, fairness, overrun, alarm and reset
module tb_dist_uart_reporter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;

  logic [0:0]  sv0, al0, sv1, al1;
  logic [15:0] sd0, th0, sd1, th1, th2;
  logic [2:0]  sv2, al2;
  logic [47:0] sd2;
  logic        bz0, ov0, bz1, ov1, bz2, ov2;
  logic [7:0]  q0[$], q1[$], q2[$];

  dist_uart_reporter_if if0();
  dist_uart_reporter_if if1();
  dist_uart_reporter_if if2();

  dist_uart_reporter #(.NCH(1), .W(16), .DIGITS(5), .PREFIX_EN(0), .ZERO_BLANK(0), .HYST(2)) u0 (
    .clk(clk), .rst_n(rst_n), .sample_valid(sv0), .sample_data(sd0), .threshold(th0),
    .tx(if0), .alarm(al0), .busy(bz0), .overrun(ov0));
  dist_uart_reporter #(.NCH(1), .W(16), .DIGITS(3), .PREFIX_EN(0), .ZERO_BLANK(1), .HYST(2)) u1 (
    .clk(clk), .rst_n(rst_n), .sample_valid(sv1), .sample_data(sd1), .threshold(th1),
    .tx(if1), .alarm(al1), .busy(bz1), .overrun(ov1));
  dist_uart_reporter #(.NCH(3), .W(16), .DIGITS(5), .PREFIX_EN(1), .ZERO_BLANK(0), .HYST(2)) u2 (
    .clk(clk), .rst_n(rst_n), .sample_valid(sv2), .sample_data(sd2), .threshold(th2),
    .tx(if2), .alarm(al2), .busy(bz2), .overrun(ov2));

  always @(posedge clk) if (rst_n && if0.tx_valid && if0.tx_ready) q0.push_back(if0.tx_byte);
  always @(posedge clk) if (rst_n && if1.tx_valid && if1.tx_ready) q1.push_back(if1.tx_byte);
  always @(posedge clk) if (rst_n && if2.tx_valid && if2.tx_ready) q2.push_back(if2.tx_byte);

  task automatic send0(input logic [15:0] v);
    @(negedge clk);
    sd0 = v;
    sv0 = 1'b1;
    @(negedge clk);
    sv0 = 1'b0;
  endtask

  task automatic send1(input logic [15:0] v);
    @(negedge clk);
    sd1 = v;
    sv1 = 1'b1;
    @(negedge clk);
    sv1 = 1'b0;
  endtask

  task automatic test_reset;
    sv0 = '0; sv1 = '0; sv2 = '0;
    sd0 = '0; sd1 = '0; sd2 = '0;
    th0 = '0; th1 = '0; th2 = '0;
    if0.tx_ready = 1'b1; if1.tx_ready = 1'b1; if2.tx_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (if0.tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", if0.tx_valid);
    checks++; if (if0.tx_byte !== 8'h00) $display("FAIL reset_tx_byte: got %h want 00", if0.tx_byte);
    checks++; if (bz0 !== 1'b0) $display("FAIL reset_busy: got %b want 0", bz0);
    checks++; if (al0 !== 1'b0) $display("FAIL reset_alarm: got %b want 0", al0);
    checks++; if (ov0 !== 1'b0) $display("FAIL reset_overrun: got %b want 0", ov0);
    errors += (if0.tx_valid !== 1'b0) + (if0.tx_byte !== 8'h00) + (bz0 !== 1'b0) + (al0 !== 1'b0) + (ov0 !== 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] e[7] = '{8'h30, 8'h30, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A};
    q0.delete();
    send0(16'd123);
    for (int i = 0; i < 200 && q0.size() < 7; i++) @(negedge clk);
    checks++;
    if (q0.size() != 7) begin errors++; $display("FAIL basic_len: got %0d want 7", q0.size()); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= q0.size() || q0[i] !== e[i]) begin
        errors++;
        $display("FAIL basic_byte%0d: got %h want %h", i, (i < q0.size()) ? q0[i] : 8'hxx, e[i]);
      end
    end
    checks++;
    if (bz0 !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b want 0", bz0); end
  endtask

  task automatic test_stall;
    logic [7:0] e[7] = '{8'h36, 8'h35, 8'h35, 8'h33, 8'h35, 8'h0D, 8'h0A};
    logic       stalled = 1'b0;
    logic [7:0] held = 8'h00;
    q0.delete();
    @(negedge clk);
    sd0 = 16'd65535;
    sv0 = 1'b1;
    if0.tx_ready = 1'b0;
    for (int i = 0; i < 600 && q0.size() < 7; i++) begin
      @(negedge clk);
      sv0 = 1'b0;
      if (stalled) begin
        checks++;
        if (if0.tx_valid !== 1'b1 || if0.tx_byte !== held) begin
          errors++;
          $display("FAIL stall_stable: got valid=%b byte=%h want valid=1 byte=%h", if0.tx_valid, if0.tx_byte, held);
        end
      end
      if0.tx_ready = (i % 4 == 3);
      stalled = if0.tx_valid && !if0.tx_ready;
      held = if0.tx_byte;
    end
    if0.tx_ready = 1'b1;
    checks++;
    if (q0.size() != 7) begin errors++; $display("FAIL stall_len: got %0d want 7", q0.size()); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= q0.size() || q0[i] !== e[i]) begin
        errors++;
        $display("FAIL stall_byte%0d: got %h want %h", i, (i < q0.size()) ? q0[i] : 8'hxx, e[i]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_blank;
    logic [15:0] v[3] = '{16'd7, 16'd1500, 16'd0};
    logic [7:0]  e[3][5] = '{'{8'h20, 8'h20, 8'h37, 8'h0D, 8'h0A},
                             '{8'h39, 8'h39, 8'h39, 8'h0D, 8'h0A},
                             '{8'h20, 8'h20, 8'h30, 8'h0D, 8'h0A}};
    for (int t = 0; t < 3; t++) begin
      q1.delete();
      send1(v[t]);
      for (int i = 0; i < 200 && q1.size() < 5; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (i >= q1.size() || q1[i] !== e[t][i]) begin
          errors++;
          $display("FAIL blank_v%0d_byte%0d: got %h want %h", v[t], i, (i < q1.size()) ? q1[i] : 8'hxx, e[t][i]);
        end
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_fair;
    logic [7:0] e[18] = '{8'h41, 8'h3A, 8'h30, 8'h30, 8'h30, 8'h30, 8'h39, 8'h0D, 8'h0A,
                          8'h43, 8'h3A, 8'h30, 8'h30, 8'h30, 8'h34, 8'h30, 8'h0D, 8'h0A};
    q2.delete();
    @(negedge clk);
    sd2 = {16'd40, 16'd0, 16'd9};
    sv2 = 3'b101;
    @(negedge clk);
    sv2 = 3'b000;
    for (int i = 0; i < 300 && q2.size() < 18; i++) @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      checks++;
      if (i >= q2.size() || q2[i] !== e[i]) begin
        errors++;
        $display("FAIL fair_byte%0d: got %h want %h", i, (i < q2.size()) ? q2[i] : 8'hxx, e[i]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_overrun;
    logic [7:0] e[18] = '{8'h42, 8'h3A, 8'h30, 8'h30, 8'h30, 8'h30, 8'h35, 8'h0D, 8'h0A,
                          8'h41, 8'h3A, 8'h30, 8'h30, 8'h30, 8'h37, 8'h37, 8'h0D, 8'h0A};
    int ovcnt = 0;
    q2.delete();
    for (int i = 0; i < 300 && q2.size() < 18; i++) begin
      @(negedge clk);
      ovcnt += int'(ov2);
      sv2 = 3'b000;
      if (i == 0) begin sd2[16 +: 16] = 16'd5;  sv2 = 3'b010; end
      if (i == 3) begin sd2[0 +: 16]  = 16'd3;  sv2 = 3'b001; end
      if (i == 5) begin sd2[0 +: 16]  = 16'd77; sv2 = 3'b001; end
    end
    sv2 = 3'b000;
    checks++;
    if (ovcnt != 1) begin errors++; $display("FAIL overrun_pulses: got %0d want 1", ovcnt); end
    for (int i = 0; i < 18; i++) begin
      checks++;
      if (i >= q2.size() || q2[i] !== e[i]) begin
        errors++;
        $display("FAIL overrun_byte%0d: got %h want %h", i, (i < q2.size()) ? q2[i] : 8'hxx, e[i]);
      end
    end
  endtask

  task automatic test_alarm;
    logic [15:0] v[5] = '{16'd15, 16'd9, 16'd11, 16'd12, 16'd8};
    logic        e[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    th0 = 16'd10;
    for (int i = 0; i < 5; i++) begin
      send0(v[i]);
      checks++;
      if (al0 !== e[i]) begin errors++; $display("FAIL alarm_v%0d: got %b want %b", v[i], al0, e[i]); end
    end
  endtask

  task automatic test_reset_mid;
    int quiet = 0;
    logic woke = 1'b0;
    for (int i = 0; i < 400 && quiet < 3; i++) begin
      @(negedge clk);
      quiet = bz0 ? 0 : quiet + 1;
    end
    checks++;
    if (quiet < 3) begin errors++; $display("FAIL mid_quiet: got %0d idle cycles want 3", quiet); end
    th0 = 16'd200;
    q0.delete();
    send0(16'd123);
    for (int i = 0; i < 200 && q0.size() < 2; i++) @(negedge clk);
    checks++;
    if (if0.tx_valid !== 1'b1 || if0.tx_byte !== 8'h31) begin
      errors++;
      $display("FAIL mid_third_digit: got valid=%b byte=%h want valid=1 byte=31", if0.tx_valid, if0.tx_byte);
    end
    checks++;
    if (al0 !== 1'b1) begin errors++; $display("FAIL mid_alarm_pre: got %b want 1", al0); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (if0.tx_valid !== 1'b0) begin errors++; $display("FAIL mid_tx_valid: got %b want 0", if0.tx_valid); end
    checks++; if (bz0 !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", bz0); end
    checks++; if (al0 !== 1'b0) begin errors++; $display("FAIL mid_alarm: got %b want 0", al0); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL mid_overrun: got %b want 0", ov0); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q0.delete();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      woke |= bz0 | if0.tx_valid;
    end
    checks++;
    if (woke !== 1'b0 || q0.size() != 0) begin
      errors++;
      $display("FAIL mid_stay_idle: got active=%b bytes=%0d want active=0 bytes=0", woke, q0.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_blank();
    test_fair();
    test_overrun();
    test_alarm();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dist_uart_reporter.md
Name: dist_uart_reporter

Overview:
Multi-channel distance reporter. It latches binary distance samples from up to NCH ultrasonic channels and converts each to decimal with a sequential double-dabble converter; no divide or modulo operators are used. Each sample is streamed as an ASCII line through a valid/ready byte interface to the UART transmitter. The block also drives a per-channel proximity alarm with hysteresis. It sits between the hc_sr04 instances and uart_tx_8n1, replacing the hard-coded 5-digit print FSM.

Parameters:
NCH, 2, number of sensor channels (1..8)
W, 16, distance sample width in cm (8..20)
DIGITS, 5, decimal digits printed per sample (1..6)
PREFIX_EN, 1, 1 = prefix each line with channel letter 'A'+ch and ':'
ZERO_BLANK, 0, 1 = leading zeros printed as space (0x20); last digit always printed
HYST, 2, alarm release hysteresis in cm

Ports:
clk  in  1  system clock (int_osc domain)
rst_n  in  1  asynchronous active-low reset
sample_valid  in  NCH  per-channel one-cycle strobe, sample_data slice valid
sample_data  in  NCH*W  packed distances, channel i at [i*W +: W]
threshold  in  W  alarm assert level, sampled on each sample_valid
tx_byte  out  8  ASCII byte to UART
tx_valid  out  1  tx_byte valid
tx_ready  in  1  UART able to accept byte
alarm  out  NCH  per-channel proximity alarm (LED/buzzer)
busy  out  1  high while a line is being converted or emitted
overrun  out  1  one-cycle pulse: pending sample overwritten before being printed

Behaviour:
- Reset: tx_byte=0, tx_valid=0, alarm=0, busy=0, overrun=0, all pending flags cleared, FSM to IDLE, round-robin pointer=0. Reset mid-line aborts the line; no partial byte remains valid.
- Capture: sample_valid[i] stores the slice in hold[i] and sets pend[i]. If pend[i] is already set and channel i is not the one being loaded this cycle, the stored value is overwritten and overrun pulses. A simultaneous LOAD of channel i and a new sample on channel i: the new value is held and pend[i] stays set; no overrun.
- Byte handshake: a byte transfers when tx_valid && tx_ready. tx_byte is stable while tx_valid=1 and tx_ready=0. tx_valid is not dropped before the transfer. tx_ready may already be high when tx_valid rises.
- FSM:
  - IDLE: if any pend set, go to LOAD. Otherwise stay.
  - LOAD: pick the first pend[j] at or after the pointer, with wrap. Copy hold[j] into the converter, clear pend[j], set pointer to j+1 mod NCH. Go to CONV.
  - CONV: wait for the converter done pulse (W+1 cycles after start). Go to PFX if PREFIX_EN, else DIG.
  - PFX: emit 'A'+j. Then SEP.
  - SEP: emit ':' (0x3A). Then DIG.
  - DIG: emit DIGITS bytes, most significant first. Then CR.
  - CR: emit 0x0D. Then LF.
  - LF: emit 0x0A. Then IDLE.
- busy=1 in every state except IDLE.
- Saturation: if the value is ≥ 10^DIGITS, every digit prints '9' (0x39). Detect this from the BCD overflow above digit DIGITS-1, not by a constant compare.
- ZERO_BLANK: a digit prints as 0x20 while it is '0' and all more-significant digits were blanked. The final digit is never blanked. Value 0 prints as spaces followed by '0'.
- Alarm, independent of the FSM and updated on sample_valid[i]:
  - alarm[i] sets when data < threshold.
  - alarm[i] clears when data ≥ threshold+HYST. Compute this sum at W+1 bits; no wrap.
  - Otherwise alarm[i] holds.
  - threshold=0 means alarm never sets.
- Fairness: with all channels pending continuously, lines go out in order 0,1,…,NCH-1,0.

Decomposition:
- Package dist_report_pkg: ASCII constants (CR, LF, SPACE, COLON, ZERO, LETTER_A), FSM state encoding, function for BCD width (4*(DIGITS+1)).
- Sub-module bin2bcd_seq:
  - Parameters: W, DIGITS.
  - Ports: clk, rst_n, start, bin, done, bcd, ovf.
  - Shift-and-add-3, one bit per cycle.
  - done pulses W+1 cycles after start.
  - A start while busy restarts the conversion.

Test Plan:
- NCH=1, DIGITS=5, PREFIX_EN=0, tx_ready tied 1, sample 123 → bytes 30 30 31 32 33 0D 0A. busy falls one cycle after LF is accepted.
- Same setup, tx_ready toggling 1-of-4 cycles, sample 65535 → 36 35 35 33 35 0D 0A. tx_byte stays stable during every stall.
- DIGITS=3, ZERO_BLANK=1: sample 7 → 20 20 37 0D 0A. Sample 1500 → 39 39 39 0D 0A. Sample 0 → 20 20 30 0D 0A.
- NCH=3, PREFIX_EN=1: samples on ch2 and ch0 in the same cycle, values 40 and 9 → the "A:00009" line precedes "C:00040". A second ch0 sample before its line loads pulses overrun once and the new value is printed.
- Alarm, threshold=10, HYST=2: samples 15, 9, 11, 12, 8 → alarm 0,1,1,0,1.
- Assert rst_n=0 during the third digit of a line → tx_valid, busy, alarm and overrun all 0 immediately. After release, the FSM stays IDLE until a new sample arrives.
